// File: rtl/alu_pkg.sv
// Shared constants and phase encoding for the ALU front-panel stages.
package alu_pkg;
  localparam int OPW              = 5;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    PH_LEFT  = 2'b00,
    PH_RIGHT = 2'b01,
    PH_READY = 2'b10
  } phase_e;
endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw button, debounces it with a stability counter and emits
// a one-cycle pulse on each accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level, r_level_d;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;

  assign w_mismatch = r_sync[1] ^ r_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], raw};
      r_level_d <= r_level;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        // Mismatch survived the full window: accept the new level.
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_level & ~r_level_d;
endmodule

// File: rtl/operand_entry.sv
// Captures left/right 5-bit operands on debounced enter presses; clear
// restarts entry. Outputs are driven straight from registers.
module operand_entry
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [OPW-1:0]   sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [2*OPW-1:0] operands,
  output logic             operands_valid,
  output logic [1:0]       phase
);
  logic [1:0][OPW-1:0] r_sw_sync;
  logic                w_ent_press, w_clr_press;

  phase_e         r_state, w_state_nxt;
  logic [OPW-1:0] r_left, r_right, w_left_nxt, w_right_nxt;
  logic           r_valid, w_valid_nxt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .reset_n(reset_n), .raw(btn_enter), .level(), .press(w_ent_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .reset_n(reset_n), .raw(btn_clear), .level(), .press(w_clr_press)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sw_sync <= '0;
    else          r_sw_sync <= {r_sw_sync[0], sw};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= PH_LEFT;
      r_left  <= '0;
      r_right <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_left  <= w_left_nxt;
      r_right <= w_right_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_left_nxt  = r_left;
    w_right_nxt = r_right;
    w_valid_nxt = r_valid;
    // Clear has priority; a coincident enter is dropped.
    if (w_clr_press) begin
      w_state_nxt = PH_LEFT;
      w_left_nxt  = '0;
      w_right_nxt = '0;
      w_valid_nxt = 1'b0;
    end else if (w_ent_press) begin
      case (r_state)
        PH_LEFT, PH_READY: begin
          w_state_nxt = PH_RIGHT;
          w_left_nxt  = r_sw_sync[1];
          w_right_nxt = '0;
          w_valid_nxt = 1'b0;
        end
        PH_RIGHT: begin
          w_state_nxt = PH_READY;
          w_right_nxt = r_sw_sync[1];
          w_valid_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = PH_LEFT;
          w_left_nxt  = '0;
          w_right_nxt = '0;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign operands       = {r_left, r_right};
  assign operands_valid = r_valid;
  assign phase          = r_state;
endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with DEBOUNCE_CYCLES=4.
module tb_operand_entry;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] sw = '0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [9:0] operands;
  logic       operands_valid;
  logic [1:0] phase;

  int checks = 0;
  int failures = 0;
  logic [12:0] exp_v;

  operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .btn_enter(btn_enter),
    .btn_clear(btn_clear), .operands(operands),
    .operands_valid(operands_valid), .phase(phase)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and park on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({operands, operands_valid, phase} !== 13'd0) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", {operands, operands_valid, phase}, 13'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      checks++;
      if ({operands, operands_valid, phase} !== 13'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, {operands, operands_valid, phase}, 13'd0);
      end
    end
  endtask

  task automatic test_capture;
    sw = 5'b00101; btn_enter = 1'b1;
    tick(6);
    checks++;
    if ({operands, operands_valid, phase} !== 13'd0) begin
      failures++;
      $display("FAIL cap_left_early got=%b exp=%b", {operands, operands_valid, phase}, 13'd0);
    end
    tick(1);
    exp_v = {10'b00101_00000, 1'b0, 2'b01};
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL cap_left got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
    btn_enter = 1'b0;
    tick(10);
    sw = 5'b11011; btn_enter = 1'b1;
    tick(6);
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL cap_right_early got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
    tick(1);
    exp_v = {10'b00101_11011, 1'b1, 2'b10};
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL cap_right got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
    btn_enter = 1'b0;
    tick(10);
  endtask

  task automatic test_ready_restart;
    sw = 5'b10000; btn_enter = 1'b1;
    tick(7);
    exp_v = {10'b10000_00000, 1'b0, 2'b01};
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL ready_restart got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
    btn_enter = 1'b0;
    tick(10);
    sw = 5'b01111; btn_enter = 1'b1;
    tick(7);
    exp_v = {10'b10000_01111, 1'b1, 2'b10};
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL extremes got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
    btn_enter = 1'b0;
    tick(10);
  endtask

  task automatic test_clear;
    btn_clear = 1'b1;
    tick(6);
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL clear_early got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
    tick(1);
    checks++;
    if ({operands, operands_valid, phase} !== 13'd0) begin
      failures++;
      $display("FAIL clear got=%b exp=%b", {operands, operands_valid, phase}, 13'd0);
    end
    btn_clear = 1'b0;
    tick(10);
  endtask

  task automatic test_glitch;
    sw = 5'b01010; btn_enter = 1'b1;
    tick(3);
    btn_enter = 1'b0;
    tick(12);
    checks++;
    if ({operands, operands_valid, phase} !== 13'd0) begin
      failures++;
      $display("FAIL glitch3 got=%b exp=%b", {operands, operands_valid, phase}, 13'd0);
    end
  endtask

  task automatic test_bounce;
    logic [19:0] pat;
    pat = 20'b1101_1001_0110_1101_0010;
    for (int i = 19; i >= 0; i--) begin
      btn_enter = pat[i];
      tick(1);
    end
    checks++;
    if ({operands, operands_valid, phase} !== 13'd0) begin
      failures++;
      $display("FAIL bounce_only got=%b exp=%b", {operands, operands_valid, phase}, 13'd0);
    end
    btn_enter = 1'b1;
    tick(10);
    btn_enter = 1'b0;
    tick(10);
    exp_v = {10'b01010_00000, 1'b0, 2'b01};
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL bounce_one got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    sw = 5'b00011; btn_enter = 1'b1; btn_clear = 1'b1;
    tick(7);
    checks++;
    if ({operands, operands_valid, phase} !== 13'd0) begin
      failures++;
      $display("FAIL enter_clear got=%b exp=%b", {operands, operands_valid, phase}, 13'd0);
    end
    btn_enter = 1'b0; btn_clear = 1'b0;
    tick(10);
    checks++;
    if ({operands, operands_valid, phase} !== 13'd0) begin
      failures++;
      $display("FAIL enter_clear_rel got=%b exp=%b", {operands, operands_valid, phase}, 13'd0);
    end
  endtask

  task automatic test_reset_mid;
    sw = 5'b00111; btn_enter = 1'b1;
    tick(7);
    exp_v = {10'b00111_00000, 1'b0, 2'b01};
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL pre_rst got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
    btn_enter = 1'b0;
    tick(10);
    sw = 5'b11100; btn_enter = 1'b1;
    tick(3);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({operands, operands_valid, phase} !== 13'd0) begin
      failures++;
      $display("FAIL rst_async got=%b exp=%b", {operands, operands_valid, phase}, 13'd0);
    end
    tick(2);
    reset_n = 1'b1;
    tick(6);
    checks++;
    if ({operands, operands_valid, phase} !== 13'd0) begin
      failures++;
      $display("FAIL rst_held_early got=%b exp=%b", {operands, operands_valid, phase}, 13'd0);
    end
    tick(1);
    exp_v = {10'b11100_00000, 1'b0, 2'b01};
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL rst_held_cap got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
    btn_enter = 1'b0;
    tick(10);
    checks++;
    if ({operands, operands_valid, phase} !== exp_v) begin
      failures++;
      $display("FAIL rst_held_once got=%b exp=%b", {operands, operands_valid, phase}, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_ready_restart();
    test_clear();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
